led_tick_ctrl: RTL and testbench
================================

// Module: led_tick_ctrl
// PURPOSE
//  Upstream pacing stage for the 3-LED chaser. Turns two raw push-buttons into a
//  one-cycle step pulse `tick` that the chaser uses to advance one LED position.
//  Buttons select step rate (4 speeds) and pause/resume; the chaser holds no timer.
// PARAMETERS
//  TICK_PERIOD  100_000_000  clk cycles per tick at speed 0 (1 s at 100 MHz); >=16
//  DEB_CYCLES   1_000_000    cycles a synchronised button must stay stable (10 ms)
//  CNT_W        32           width of tick counter; must hold TICK_PERIOD-1
// PORTS
//  clk        in   1      system clock, 100 MHz, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  btn_speed  in   1      raw async button, high = pressed; press advances speed
//  btn_pause  in   1      raw async button, high = pressed; press toggles run/pause
//  tick       out  1      one-cycle pulse, advance chaser one step
//  running    out  1      1 = RUN state, 0 = PAUSED
//  speed      out  2      current speed index 0..3
// BEHAVIOUR
//  Reset (rst=1 at posedge): tick=0, running=1 (RUN), speed=0, tick counter=0,
//   synchronisers/debouncers cleared to 0 (released). rst overrides all else.
//  Button path (per button): 2-FF synchroniser -> debouncer -> rising-edge detect.
//   Debounced level changes only after synced input differs from it for
//   DEB_CYCLES consecutive cycles; any bounce restarts the stability count.
//   Press event = 1-cycle pulse on debounced 0->1; release generates nothing.
//   Latency raw edge -> press pulse: 2 + DEB_CYCLES + 1 cycles.
//   Holding a button yields exactly one event.
//  Period: period = TICK_PERIOD >> speed (speed 0..3 = 1, 1/2, 1/4, 1/8 of base).
//  FSM states: RUN, PAUSED. pause press: RUN->PAUSED, PAUSED->RUN.
//  RUN: counter increments each cycle; at count == period-1, count<=0, tick=1
//   next cycle (tick registered, exactly 1 cycle wide). First tick after reset
//   or resume from count 0 appears `period` cycles later.
//  PAUSED: counter holds value, tick=0; resume continues from held count.
//  speed press: speed <= speed+1, wrapping 3->0; counter cleared to 0 same cycle,
//   no tick emitted that cycle even if count was at terminal value.
//  Simultaneous speed+pause press: both apply in same cycle (speed advances,
//   counter cleared, state toggles); no tick that cycle.
//  Pause press in the cycle count hits period-1 while RUN: the terminal tick is
//   emitted, counter wraps to 0, state becomes PAUSED.
//  Counter arithmetic unsigned CNT_W bits; compare uses current-cycle period.
// STRUCTURE
//  Shared package/header: state encodings ST_RUN/ST_PAUSED, SPEED_W=2,
//   default TICK_PERIOD and DEB_CYCLES constants for 100 MHz board.
//  One sub-module: btn_debounce (sync + debounce + rise pulse, param DEB_CYCLES),
//   instantiated twice. Tick counter and FSM live in led_tick_ctrl.
// TESTING (bench params TICK_PERIOD=16, DEB_CYCLES=4)
//  1 Reset then idle 100 cycles -> tick every 16 cycles, first at cycle 16;
//    running=1, speed=0.
//  2 Clean speed press x3 -> speed 1,2,3, tick spacing 8,4,2; 4th press -> speed 0,
//    spacing 16; each press clears counter, no tick on press cycle.
//  3 btn_speed bounces 1,0,1,0 every 2 cycles then holds 1 for 10 -> exactly one
//    speed increment, 2+4+1 cycles after final rising edge.
//  4 Pause at count 5 -> running=0, no ticks for 50 cycles; resume -> next tick
//    after 11 cycles (count resumes at 5).
//  5 Both buttons pressed same cycle in RUN at speed 0 -> speed=1, running=0,
//    no tick; pause again -> first tick 8 cycles later.
//  6 rst asserted mid-period in PAUSED at speed 2 -> next cycle running=1,
//    speed=0, tick=0, counter 0; tick 16 cycles after rst release.

Source files
------------

// File: rtl/led_tick_ctrl_pkg.sv
// Shared definitions for the LED chaser pacing stage: run/pause state
// encoding, speed index width and default timing for the 100 MHz board.
package led_tick_ctrl_pkg;

  localparam int SPEED_W         = 2;
  localparam int DEF_TICK_PERIOD = 100_000_000;
  localparam int DEF_DEB_CYCLES  = 1_000_000;
  localparam int DEF_CNT_W       = 32;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } run_state_e;

endpackage

// File: rtl/led_tick_ctrl_btn_debounce.sv
// One push-button front end: two-flop synchroniser, stability-count
// debouncer and a registered one-cycle pulse on the debounced press edge.
module led_tick_ctrl_btn_debounce
  import led_tick_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             debLevel_q;
  logic             debLevel_d;
  logic             debPrev_q;
  logic [DEB_W-1:0] stableCnt_q;
  logic [DEB_W-1:0] stableCnt_d;
  logic             press_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES cycles in a row; any agreement restarts the count.
  always_comb begin
    stableCnt_d = '0;
    debLevel_d  = debLevel_q;
    if (sync2_q != debLevel_q) begin
      if (stableCnt_q == DEB_LAST) begin
        debLevel_d = sync2_q;
      end else begin
        stableCnt_d = stableCnt_q + DEB_W'(1);
      end
    end
  end

  // Hold the debounced level and emit a single-cycle pulse when it goes from released to pressed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stableCnt_q <= '0;
      debLevel_q  <= 1'b0;
      debPrev_q   <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      stableCnt_q <= stableCnt_d;
      debLevel_q  <= debLevel_d;
      debPrev_q   <= debLevel_q;
      press_q     <= debLevel_q & ~debPrev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_tick_ctrl.sv
// Pacing stage for the 3-LED chaser: turns the speed and pause buttons
// into a paced one-cycle step pulse with four rates and run/pause control.
module led_tick_ctrl
  import led_tick_ctrl_pkg::*;
#(
  parameter int TICK_PERIOD = DEF_TICK_PERIOD,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_speed,
  input  logic               btn_pause,
  output logic               tick,
  output logic               running,
  output logic [SPEED_W-1:0] speed
);

  logic               speedPress;
  logic               pausePress;
  run_state_e         state_q;
  run_state_e         state_d;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] speed_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               tick_q;
  logic               tick_d;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   periodLast;

  led_tick_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uSpeedBtn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_speed),
    .press_o (speedPress)
  );

  led_tick_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uPauseBtn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_pause),
    .press_o (pausePress)
  );

  assign period     = CNT_W'(TICK_PERIOD) >> speed_q;
  assign periodLast = period - CNT_W'(1);

  // Run/pause state register; reset starts the chaser running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Each pause press flips between running and paused.
  always_comb begin
    state_d = state_q;
    if (pausePress) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  // Decode the externally visible run flag from the state.
  always_comb begin
    running = 1'b0;
    if (state_q == ST_RUN) begin
      running = 1'b1;
    end
  end

  // Speed press restarts the period at the new rate; otherwise count while running and pulse on the terminal count.
  always_comb begin
    speed_d = speed_q;
    count_d = count_q;
    tick_d  = 1'b0;
    if (speedPress) begin
      speed_d = speed_q + SPEED_W'(1);
      count_d = '0;
    end else if (state_q == ST_RUN) begin
      if (count_q == periodLast) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Register speed, period counter and the step pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      speed_q <= speed_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_led_tick_ctrl.sv
// Directed bench for led_tick_ctrl with a short tick period and debounce time.
module tb_led_tick_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_speed;
  logic       btn_pause;
  logic       tick;
  logic       running;
  logic [1:0] speed;

  int checkCount = 0;
  int failCount  = 0;

  led_tick_ctrl #(
    .TICK_PERIOD (16),
    .DEB_CYCLES  (4),
    .CNT_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_speed (btn_speed),
    .btn_pause (btn_pause),
    .tick      (tick),
    .running   (running),
    .speed     (speed)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hold the chosen buttons from this negedge; returns 8 negedges later, when
  // the press has been synchronised, debounced, pulsed and applied.
  task automatic applyStimulus(input logic s, input logic p);
    btn_speed = s;
    btn_pause = p;
    repeat (8) @(negedge clk);
    btn_speed = 1'b0;
    btn_pause = 1'b0;
  endtask

  // Count negedges until tick is seen high, giving up after maxN.
  task automatic waitTick(input int maxN, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < maxN);
  endtask

  initial begin
    int n;
    int tickSeen;
    int expSpeed[4];
    int expPeriod[4];
    expSpeed  = '{1, 2, 3, 0};
    expPeriod = '{8, 4, 2, 16};

    rst       = 1'b1;
    btn_speed = 1'b0;
    btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset and free-running ticks");
    checkOutput("reset_tick", 32'(tick), 0);
    checkOutput("reset_running", 32'(running), 1);
    checkOutput("reset_speed", 32'(speed), 0);
    waitTick(40, n);
    checkOutput("first_tick", n, 16);
    for (int i = 0; i < 5; i++) begin
      waitTick(40, n);
      checkOutput("tick_spacing_s0", n, 16);
    end

    $display("[TB] speed presses");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("speed_press_no_tick", 32'(tick), 0);
      checkOutput("speed_value", 32'(speed), expSpeed[i]);
      waitTick(40, n);
      checkOutput("speed_first_tick", n, expPeriod[i]);
      waitTick(40, n);
      checkOutput("speed_spacing", n, expPeriod[i]);
      repeat (12) @(negedge clk);
    end

    $display("[TB] pause mid-period and resume");
    waitTick(40, n);
    repeat (13) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pause_running", 32'(running), 0);
    checkOutput("pause_tick", 32'(tick), 0);
    tickSeen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tick === 1'b1) tickSeen++;
    end
    checkOutput("paused_tick_count", tickSeen, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("resume_running", 32'(running), 1);
    waitTick(40, n);
    checkOutput("resume_tick_delay", n, 11);

    $display("[TB] pause on terminal count");
    repeat (8) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("term_pause_tick", 32'(tick), 1);
    checkOutput("term_pause_running", 32'(running), 0);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("term_resume_running", 32'(running), 1);
    waitTick(40, n);
    checkOutput("term_resume_tick_delay", n, 16);

    $display("[TB] simultaneous speed and pause");
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_speed", 32'(speed), 1);
    checkOutput("both_running", 32'(running), 0);
    checkOutput("both_tick", 32'(tick), 0);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("both_resume_running", 32'(running), 1);
    waitTick(40, n);
    checkOutput("both_resume_tick_delay", n, 8);

    $display("[TB] bouncing speed button");
    repeat (10) @(negedge clk);
    btn_speed = 1'b1;
    repeat (2) @(negedge clk);
    btn_speed = 1'b0;
    repeat (2) @(negedge clk);
    btn_speed = 1'b1;
    repeat (2) @(negedge clk);
    btn_speed = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("bounce_speed_before", 32'(speed), 1);
    btn_speed = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("bounce_speed_early", 32'(speed), 1);
    @(negedge clk);
    checkOutput("bounce_speed_after", 32'(speed), 2);
    repeat (2) @(negedge clk);
    btn_speed = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("bounce_speed_single", 32'(speed), 2);

    $display("[TB] reset while paused");
    applyStimulus(1'b0, 1'b1);
    checkOutput("pre_reset_running", 32'(running), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_running", 32'(running), 1);
    checkOutput("rst_speed", 32'(speed), 0);
    checkOutput("rst_tick", 32'(tick), 0);
    rst = 1'b0;
    waitTick(40, n);
    checkOutput("rst_first_tick", n, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
